// File: rtl/ex_operand_bypass_net.sv
// ex_operand_bypass_net: EX operand bypass (MEM > WB > commit history > RF), ALU source muxes, load-use detect.
// Define BYPASS_STATS_EN to add saturating hit/stall counters.
module ex_operand_bypass_net #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int HIST_DEPTH     = 2,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_EX,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_EX,
    input  logic [DATA_WIDTH-1:0]     rd1_EX,
    input  logic [DATA_WIDTH-1:0]     rd2_EX,
    input  logic [DATA_WIDTH-1:0]     pc_EX,
    input  logic [DATA_WIDTH-1:0]     imm_EX,
    input  logic                      alu_sel_rs1_EX,
    input  logic [1:0]                alu_sel_rs2_EX,
    input  logic [REG_ADDR_WIDTH-1:0] rd_MEM,
    input  logic                      we_MEM,
    input  logic                      is_load_MEM,
    input  logic [DATA_WIDTH-1:0]     alu_res_MEM,
    input  logic [REG_ADDR_WIDTH-1:0] rd_WB,
    input  logic                      we_WB,
    input  logic [DATA_WIDTH-1:0]     result_WB,
    input  logic                      hist_clear,
    output logic [DATA_WIDTH-1:0]     fwd_rs1,
    output logic [DATA_WIDTH-1:0]     fwd_rs2,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [1:0]                fwd_src_rs1,
    output logic [1:0]                fwd_src_rs2,
    output logic                      load_use_stall
`ifdef BYPASS_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]     stat_mem_hits,
    output logic [STAT_WIDTH-1:0]     stat_wb_hits,
    output logic [STAT_WIDTH-1:0]     stat_hist_hits,
    output logic [STAT_WIDTH-1:0]     stat_stalls
`endif
);
    if (HIST_DEPTH < 1 || HIST_DEPTH > 8 || STAT_WIDTH < 1) begin : g_bad_param
        $error("ex_operand_bypass_net: HIST_DEPTH must be 1..8");
    end

    logic [HIST_DEPTH-1:0]     hv;
    logic [REG_ADDR_WIDTH-1:0] hr [HIST_DEPTH];
    logic [DATA_WIDTH-1:0]     hd [HIST_DEPTH];
    logic                      push, st1, st2;

    assign push = we_WB && rd_WB != '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) hv <= '0;
        else if (hist_clear) hv <= '0;
        else if (push) hv <= (hv << 1) | HIST_DEPTH'(1);

    // Entry payload needs no reset: it is only observed through hv.
    always_ff @(posedge clk)
        if (push) begin
            hr[0] <= rd_WB;
            hd[0] <= result_WB;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hr[i] <= hr[i-1];
                hd[i] <= hd[i-1];
            end
        end

    // Lowest priority applied first so later hits override; a load in MEM falls through.
    function automatic logic [DATA_WIDTH+2:0] pick(input logic [REG_ADDR_WIDTH-1:0] rs,
                                                   input logic [DATA_WIDTH-1:0] rf);
        logic [1:0]            s;
        logic [DATA_WIDTH-1:0] d;
        logic                  st;
        s  = 2'd0;
        d  = rf;
        st = 1'b0;
        if (rs != '0) begin
            for (int i = HIST_DEPTH - 1; i >= 0; i--)
                if (hv[i] && hr[i] == rs) begin s = 2'd3; d = hd[i]; end
            if (we_WB && rd_WB == rs) begin s = 2'd2; d = result_WB; end
            if (we_MEM && rd_MEM == rs) begin
                if (is_load_MEM) st = 1'b1;
                else begin s = 2'd1; d = alu_res_MEM; end
            end
        end
        return {st, s, d};
    endfunction

    always_comb begin
        {st1, fwd_src_rs1, fwd_rs1} = pick(rs1_addr_EX, rd1_EX);
        {st2, fwd_src_rs2, fwd_rs2} = pick(rs2_addr_EX, rd2_EX);
        load_use_stall = st1 | st2;
        alu_a = alu_sel_rs1_EX ? pc_EX : fwd_rs1;
        alu_b = alu_sel_rs2_EX == 2'd0 ? fwd_rs2 : alu_sel_rs2_EX == 2'd2 ? DATA_WIDTH'(4) : imm_EX;
    end

`ifdef BYPASS_STATS_EN
    function automatic logic [STAT_WIDTH-1:0] sat(input logic [STAT_WIDTH-1:0] c, input logic [1:0] n);
        logic [STAT_WIDTH:0] s;
        s = {1'b0, c} + (STAT_WIDTH + 1)'(n);
        return s[STAT_WIDTH] ? '1 : s[STAT_WIDTH-1:0];
    endfunction

    function automatic logic [1:0] cnt2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stat_mem_hits  <= '0;
            stat_wb_hits   <= '0;
            stat_hist_hits <= '0;
            stat_stalls    <= '0;
        end else begin
            stat_mem_hits  <= sat(stat_mem_hits,  cnt2(fwd_src_rs1 == 2'd1, fwd_src_rs2 == 2'd1));
            stat_wb_hits   <= sat(stat_wb_hits,   cnt2(fwd_src_rs1 == 2'd2, fwd_src_rs2 == 2'd2));
            stat_hist_hits <= sat(stat_hist_hits, cnt2(fwd_src_rs1 == 2'd3, fwd_src_rs2 == 2'd3));
            stat_stalls    <= sat(stat_stalls,    cnt2(st1, st2));
        end
`endif
endmodule

// File: tb/tb_ex_operand_bypass_net.sv
// tb_ex_operand_bypass_net: directed + random checks of the bypass network against a queue-based model.
module tb_ex_operand_bypass_net;
    logic        clk, rst;
    logic [4:0]  rs1_addr_EX, rs2_addr_EX, rd_MEM, rd_WB;
    logic [31:0] rd1_EX, rd2_EX, pc_EX, imm_EX, alu_res_MEM, result_WB;
    logic        alu_sel_rs1_EX, we_MEM, is_load_MEM, we_WB, hist_clear;
    logic [1:0]  alu_sel_rs2_EX;
    logic [31:0] fwd_rs1, fwd_rs2, alu_a, alu_b;
    logic [1:0]  fwd_src_rs1, fwd_src_rs2;
    logic        load_use_stall;
`ifdef BYPASS_STATS_EN
    logic [15:0] stat_mem_hits, stat_wb_hits, stat_hist_hits, stat_stalls;
    int          cm, cw, ch, cs;
`endif

    typedef struct {logic [4:0] rd; logic [31:0] data;} ent_t;
    ent_t hq[$];
    int   total = 0, bad = 0;

    ex_operand_bypass_net dut (
        .clk(clk), .rst(rst), .rs1_addr_EX(rs1_addr_EX), .rs2_addr_EX(rs2_addr_EX),
        .rd1_EX(rd1_EX), .rd2_EX(rd2_EX), .pc_EX(pc_EX), .imm_EX(imm_EX),
        .alu_sel_rs1_EX(alu_sel_rs1_EX), .alu_sel_rs2_EX(alu_sel_rs2_EX),
        .rd_MEM(rd_MEM), .we_MEM(we_MEM), .is_load_MEM(is_load_MEM), .alu_res_MEM(alu_res_MEM),
        .rd_WB(rd_WB), .we_WB(we_WB), .result_WB(result_WB), .hist_clear(hist_clear),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .alu_a(alu_a), .alu_b(alu_b),
        .fwd_src_rs1(fwd_src_rs1), .fwd_src_rs2(fwd_src_rs2), .load_use_stall(load_use_stall)
`ifdef BYPASS_STATS_EN
        , .stat_mem_hits(stat_mem_hits), .stat_wb_hits(stat_wb_hits),
        .stat_hist_hits(stat_hist_hits), .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the first matching source in priority order; history searched youngest first.
    function automatic void ref_op(input logic [4:0] rs, input logic [31:0] rf,
                                   output logic [31:0] d, output logic [1:0] s, output logic st);
        d = rf; s = 0; st = 0;
        if (rs == 0) return;
        if (we_MEM && rd_MEM == rs) begin
            if (is_load_MEM) st = 1;
            else begin d = alu_res_MEM; s = 1; return; end
        end
        if (we_WB && rd_WB == rs) begin d = result_WB; s = 2; return; end
        foreach (hq[i]) if (hq[i].rd == rs) begin d = hq[i].data; s = 3; return; end
    endfunction

    task automatic full(input string tag);
        logic [31:0] e1, e2, eb;
        logic [1:0]  s1, s2;
        logic        t1, t2;
        ref_op(rs1_addr_EX, rd1_EX, e1, s1, t1);
        ref_op(rs2_addr_EX, rd2_EX, e2, s2, t2);
        eb = alu_sel_rs2_EX == 0 ? e2 : alu_sel_rs2_EX == 2 ? 32'd4 : imm_EX;
        chk({tag, ".fwd_rs1"}, fwd_rs1, e1);
        chk({tag, ".fwd_rs2"}, fwd_rs2, e2);
        chk({tag, ".src1"}, fwd_src_rs1, s1);
        chk({tag, ".src2"}, fwd_src_rs2, s2);
        chk({tag, ".stall"}, load_use_stall, t1 | t2);
        chk({tag, ".alu_a"}, alu_a, alu_sel_rs1_EX ? pc_EX : e1);
        chk({tag, ".alu_b"}, alu_b, eb);
`ifdef BYPASS_STATS_EN
        chk({tag, ".st_mem"}, stat_mem_hits, cm);
        chk({tag, ".st_wb"}, stat_wb_hits, cw);
        chk({tag, ".st_hist"}, stat_hist_hits, ch);
        chk({tag, ".st_stall"}, stat_stalls, cs);
`endif
    endtask

    task automatic tick();
`ifdef BYPASS_STATS_EN
        logic [31:0] d1, d2;
        logic [1:0]  s1, s2;
        logic        t1, t2;
        ref_op(rs1_addr_EX, rd1_EX, d1, s1, t1);
        ref_op(rs2_addr_EX, rd2_EX, d2, s2, t2);
`endif
        @(posedge clk);
`ifdef BYPASS_STATS_EN
        if (rst) begin cm = 0; cw = 0; ch = 0; cs = 0; end
        else begin
            cm = cm + (s1 == 1) + (s2 == 1); if (cm > 65535) cm = 65535;
            cw = cw + (s1 == 2) + (s2 == 2); if (cw > 65535) cw = 65535;
            ch = ch + (s1 == 3) + (s2 == 3); if (ch > 65535) ch = 65535;
            cs = cs + t1 + t2;               if (cs > 65535) cs = 65535;
        end
`endif
        if (rst || hist_clear) hq.delete();
        else if (we_WB && rd_WB != 0) begin
            hq.push_front('{rd_WB, result_WB});
            if (hq.size() > 2) void'(hq.pop_back());
        end
        #1;
    endtask

    task automatic idle();
        {rs1_addr_EX, rs2_addr_EX, rd_MEM, rd_WB} = '0;
        {rd1_EX, rd2_EX, pc_EX, imm_EX, alu_res_MEM, result_WB} = '0;
        {alu_sel_rs1_EX, we_MEM, is_load_MEM, we_WB, hist_clear, alu_sel_rs2_EX} = '0;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] v);
        idle(); we_WB = 1; rd_WB = r; result_WB = v;
        tick();
    endtask

    initial begin
`ifdef BYPASS_STATS_EN
        cm = 0; cw = 0; ch = 0; cs = 0;
`endif
        idle(); rst = 1;
        tick(); tick();
        rs1_addr_EX = 5; rd1_EX = 32'h1234; #3 full("reset");
        rst = 0; tick();

        idle(); we_MEM = 1; rd_MEM = 5; alu_res_MEM = 32'h11; rs1_addr_EX = 5;
        we_WB = 1; rd_WB = 5; result_WB = 32'h22; #3;
        chk("memfwd.data", fwd_rs1, 32'h11); chk("memfwd.src", fwd_src_rs1, 2'd1);
        chk("memfwd.stall", load_use_stall, 1'b0); full("memfwd"); tick();

        idle(); we_MEM = 1; is_load_MEM = 1; rd_MEM = 7; rs2_addr_EX = 7;
        we_WB = 1; rd_WB = 7; result_WB = 32'h33; #3;
        chk("lu.stall", load_use_stall, 1'b1); chk("lu.data", fwd_rs2, 32'h33);
        chk("lu.src", fwd_src_rs2, 2'd2); full("loaduse"); tick();

        commit(3, 32'hA); commit(4, 32'hB); commit(9, 32'hC);
        idle(); rs1_addr_EX = 3; rd1_EX = 32'hDEAD; #3;
        chk("age.src", fwd_src_rs1, 2'd0); chk("age.data", fwd_rs1, 32'hDEAD); full("aged"); tick();
        commit(3, 32'hA); commit(4, 32'hB);
        idle(); rs1_addr_EX = 3; rd1_EX = 32'hDEAD; rs2_addr_EX = 4; #3;
        chk("hist.src", fwd_src_rs1, 2'd3); chk("hist.data", fwd_rs1, 32'hA); full("hist"); tick();

        idle(); we_MEM = 1; rd_MEM = 0; alu_res_MEM = 32'hFF; #3;
        chk("x0.data", fwd_rs1, 32'h0); chk("x0.src", fwd_src_rs1, 2'd0); full("x0"); tick();

        idle(); hist_clear = 1; we_WB = 1; rd_WB = 6; result_WB = 32'h5; tick();
        idle(); rs1_addr_EX = 6; rd1_EX = 32'h77; rs2_addr_EX = 3; #3;
        chk("clr.src", fwd_src_rs1, 2'd0); full("clear"); tick();

        idle(); alu_sel_rs1_EX = 1; pc_EX = 32'h100; alu_sel_rs2_EX = 2; imm_EX = 32'h9; #3;
        chk("mux.a", alu_a, 32'h100); chk("mux.b", alu_b, 32'h4); full("mux"); tick();

        commit(8, 32'h88);
        idle(); rs1_addr_EX = 8; rd1_EX = 32'h1; #2;
        chk("pre_rst.src", fwd_src_rs1, 2'd3);
        #1 rst = 1; hq.delete();
`ifdef BYPASS_STATS_EN
        cm = 0; cw = 0; ch = 0; cs = 0;
`endif
        #1 chk("async_rst.src", fwd_src_rs1, 2'd0); full("async_rst");
        #1 rst = 0; tick();

        for (int n = 0; n < 400; n++) begin
            rs1_addr_EX = 5'($urandom_range(0, 7)); rs2_addr_EX = 5'($urandom_range(0, 7));
            rd_MEM = 5'($urandom_range(0, 7));      rd_WB = 5'($urandom_range(0, 7));
            rd1_EX = $urandom; rd2_EX = $urandom; pc_EX = $urandom; imm_EX = $urandom;
            alu_res_MEM = $urandom; result_WB = $urandom;
            alu_sel_rs1_EX = 1'($urandom); alu_sel_rs2_EX = 2'($urandom);
            we_MEM = 1'($urandom); is_load_MEM = $urandom_range(0, 3) == 0;
            we_WB = $urandom_range(0, 3) != 0; hist_clear = $urandom_range(0, 15) == 0;
            #3 full("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
